// File: rtl/opl3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | opl3_pkg                                                             |
// | Shared widths, defaults and ym_smp encodings for the YMF262 stream.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package opl3_pkg;

   localparam int c_sample_w      = 16;
   localparam int c_def_dclk_div  = 16;
   localparam int c_def_idle_bits = 4;

   typedef enum logic [1:0] {
      SMP_IDLE  = 2'b00,
      SMP_LEFT  = 2'b01,
      SMP_RIGHT = 2'b10
   } smp_e;

endpackage
`default_nettype wire

// File: rtl/ym_stream_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ym_stream_tx_if                                                      |
// | Valid/ready stereo sample handshake feeding the YMF262 serialiser.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ym_stream_tx_if;
   import opl3_pkg::*;

   logic                  s_valid;
   logic                  s_ready;
   logic [c_sample_w-1:0] s_left;
   logic [c_sample_w-1:0] s_right;

   modport master (output s_valid, output s_left, output s_right, input s_ready);
   modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface
`default_nettype wire

// File: rtl/ym_dclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ym_dclk_gen                                                          |
// | Divides clk28 into the 50 % duty ym_dclk and flags its falling edge. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ym_dclk_gen
   import opl3_pkg::*;
#(
   parameter int DCLK_DIV = c_def_dclk_div
) (
   input  wire  clk28,
   input  wire  rst,
   output logic o_dclk,
   output logic o_fall
);

   localparam int                 c_cnt_w   = $clog2(DCLK_DIV);
   localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(DCLK_DIV / 2 - 1);
   localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(DCLK_DIV - 1);

   logic [c_cnt_w-1:0] r_div_cnt;
   logic               r_dclk;
   logic               w_rise;
   logic               w_fall;

   // Strobes mark the clk28 edge on which ym_dclk changes, so the framer
   // can update data on exactly the same edge as the falling bit clock.
   assign w_rise = (r_div_cnt == c_half_m1);
   assign w_fall = (r_div_cnt == c_last);

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_dclk    <= 1'b0;
      end else begin
         r_div_cnt <= w_fall ? '0 : r_div_cnt + 1'b1;
         if (w_rise) begin
            r_dclk <= 1'b1;
         end else if (w_fall) begin
            r_dclk <= 1'b0;
         end
      end
   end

   assign o_dclk = r_dclk;
   assign o_fall = w_fall;

endmodule
`default_nettype wire

// File: rtl/ym_stream_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ym_stream_tx                                                         |
// | Serialises 16-bit stereo pairs onto the YMF262 LSB-first stream.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ym_stream_tx
   import opl3_pkg::*;
#(
   parameter int DCLK_DIV  = c_def_dclk_div,
   parameter int IDLE_BITS = c_def_idle_bits
) (
   input  wire                 clk28,
   input  wire                 rst,
   ym_stream_tx_if.slave       s_if,
   output logic                ym_dclk,
   output logic [1:0]          ym_smp,
   output logic                ym_data,
   output logic                frame_start,
   output logic                underrun
);

   localparam int                 c_frame_bits = 32 + IDLE_BITS;
   localparam int                 c_bit_w      = $clog2(c_frame_bits);
   localparam logic [c_bit_w-1:0] c_last_slot  = c_bit_w'(c_frame_bits - 1);

   logic                    w_fall;
   logic                    w_accept;
   logic [c_bit_w-1:0]      w_next_slot;
   logic [31:0]             w_slot_ext;
   logic [31:0]             w_load_word;

   logic [c_bit_w-1:0]      r_bit_cnt;
   logic [31:0]             r_hold;
   logic                    r_hold_full;
   logic [31:0]             r_last;
   logic [c_sample_w-1:0]   r_shift_l;
   logic [c_sample_w-1:0]   r_shift_r;
   smp_e                    r_smp;
   logic                    r_data;
   logic                    r_frame_start;
   logic                    r_underrun;

   ym_dclk_gen #(
      .DCLK_DIV (DCLK_DIV)
   ) u_dclk_gen (
      .clk28  (clk28),
      .rst    (rst),
      .o_dclk (ym_dclk),
      .o_fall (w_fall)
   );

   assign w_accept    = s_if.s_valid & ~r_hold_full;
   assign w_next_slot = (r_bit_cnt == c_last_slot) ? '0 : r_bit_cnt + 1'b1;
   assign w_slot_ext  = 32'(w_next_slot);
   // An empty holding register at slot 0 replays the previous frame.
   assign w_load_word = r_hold_full ? r_hold : r_last;

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         r_bit_cnt     <= c_last_slot;
         r_hold        <= '0;
         r_hold_full   <= 1'b0;
         r_last        <= '0;
         r_shift_l     <= '0;
         r_shift_r     <= '0;
         r_smp         <= SMP_IDLE;
         r_data        <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;

         if (w_accept) begin
            r_hold      <= {s_if.s_left, s_if.s_right};
            r_hold_full <= 1'b1;
         end

         if (w_fall) begin
            r_bit_cnt <= w_next_slot;
            if (w_next_slot == '0) begin
               r_frame_start <= 1'b1;
               r_underrun    <= ~r_hold_full;
               if (r_hold_full) begin
                  r_hold_full <= 1'b0;
                  r_last      <= r_hold;
               end
               // Left bit 0 goes out now; the remaining 15 bits wait in the shifter.
               r_shift_l <= {1'b0, w_load_word[31:17]};
               r_shift_r <= w_load_word[15:0];
               r_data    <= w_load_word[16];
               r_smp     <= SMP_LEFT;
            end else if (w_slot_ext < 32'd16) begin
               r_data    <= r_shift_l[0];
               r_shift_l <= r_shift_l >> 1;
               r_smp     <= SMP_LEFT;
            end else if (w_slot_ext < 32'd32) begin
               r_data    <= r_shift_r[0];
               r_shift_r <= r_shift_r >> 1;
               r_smp     <= SMP_RIGHT;
            end else begin
               r_data    <= 1'b0;
               r_smp     <= SMP_IDLE;
            end
         end
      end
   end

   assign s_if.s_ready = ~r_hold_full;
   assign ym_smp       = r_smp;
   assign ym_data      = r_data;
   assign frame_start  = r_frame_start;
   assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ym_stream_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ym_stream_tx                                                      |
// | Directed/random bench for ym_stream_tx at default and minimum sizes. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ym_stream_tx;

   typedef struct {
      logic [31:0] w;
      int          e;
   } acc_t;

   logic clk28;
   logic rst;
   logic sel;
   int   cyc;
   int   n_assert;
   int   n_fail;
   acc_t log_a[$];
   acc_t log_b[$];

   logic       dclk_a, data_a, fs_a, ur_a;
   logic [1:0] smp_a;
   logic       dclk_b, data_b, fs_b, ur_b;
   logic [1:0] smp_b;

   logic       dclk_m, data_m, fs_m, ur_m, rdy_m;
   logic [1:0] smp_m;

   ym_stream_tx_if bus_a ();
   ym_stream_tx_if bus_b ();

   ym_stream_tx #(.DCLK_DIV(16), .IDLE_BITS(4)) u_dut_a (
      .clk28 (clk28), .rst (rst), .s_if (bus_a),
      .ym_dclk (dclk_a), .ym_smp (smp_a), .ym_data (data_a),
      .frame_start (fs_a), .underrun (ur_a)
   );

   ym_stream_tx #(.DCLK_DIV(4), .IDLE_BITS(0)) u_dut_b (
      .clk28 (clk28), .rst (rst), .s_if (bus_b),
      .ym_dclk (dclk_b), .ym_smp (smp_b), .ym_data (data_b),
      .frame_start (fs_b), .underrun (ur_b)
   );

   assign dclk_m = sel ? dclk_b : dclk_a;
   assign data_m = sel ? data_b : data_a;
   assign fs_m   = sel ? fs_b   : fs_a;
   assign ur_m   = sel ? ur_b   : ur_a;
   assign smp_m  = sel ? smp_b  : smp_a;
   assign rdy_m  = sel ? bus_b.s_ready : bus_a.s_ready;

   initial clk28 = 1'b0;
   always #18 clk28 = ~clk28;

   // Edges since reset release; the frame boundaries follow from it by arithmetic.
   always @(posedge clk28 or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame m takes the oldest sample accepted strictly before its boundary,
   // otherwise it repeats the previous frame and reports an underrun.
   function automatic void model(input logic s, input int m, output logic [31:0] w,
                                 output logic ur, output logic rdy);
      int div, fb, idx, n, e;
      logic [31:0] last;
      acc_t ent;
      div = s ? 4 : 16;
      fb  = s ? 32 : 36;
      idx = 0; last = '0; ur = 1'b1; e = 0;
      n   = s ? log_b.size() : log_a.size();
      for (int f = 0; f <= m; f++) begin
         e  = div + f * div * fb;
         ur = 1'b1;
         if (idx < n) begin
            if (s) ent = log_b[idx]; else ent = log_a[idx];
            if (ent.e < e) begin last = ent.w; idx++; ur = 1'b0; end
         end
      end
      w   = last;
      rdy = 1'b1;
      if (idx < n) begin
         if (s) ent = log_b[idx]; else ent = log_a[idx];
         if (ent.e <= e) rdy = 1'b0;
      end
   endfunction

   task automatic drive(input logic v, input logic [31:0] w);
      if (sel) begin
         bus_b.s_valid = v; bus_b.s_left = w[31:16]; bus_b.s_right = w[15:0];
      end else begin
         bus_a.s_valid = v; bus_a.s_left = w[31:16]; bus_a.s_right = w[15:0];
      end
   endtask

   task automatic push(input logic [31:0] w, input int e);
      acc_t ent;
      ent.w = w; ent.e = e;
      if (sel) log_b.push_back(ent); else log_a.push_back(ent);
   endtask

   task automatic send(input logic [31:0] w);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 1400 && !ok; i++) begin
         @(negedge clk28);
         ok = rdy_m;
      end
      chk("send_ready", 64'(ok), 64'd1);
      if (ok) begin
         drive(1'b1, w);
         @(posedge clk28);
         push(w, cyc + 1);
         #1 drive(1'b0, w);
      end
   endtask

   task automatic send_at(input int edge_no, input logic [31:0] w);
      for (int i = 0; i < 4000 && cyc < edge_no - 1; i++) @(negedge clk28);
      chk("ready_before_edge", 64'(rdy_m), 64'd1);
      drive(1'b1, w);
      @(posedge clk28);
      push(w, cyc + 1);
      #1 drive(1'b0, w);
   endtask

   task automatic capture(input int m, output logic [47:0] dv);
      int div, fb, e_obs, j, nl, nr, bad_smp, bad_dclk, extra;
      logic found, ur_obs, rdy_obs, ur_exp, rdy_exp;
      logic [31:0] w_exp;
      logic [15:0] l_got, r_got;
      logic [1:0]  smp_exp;
      div = sel ? 4 : 16;
      fb  = sel ? 32 : 36;
      dv = '0; found = 1'b0; nl = 0; nr = 0; bad_smp = 0; bad_dclk = 0; extra = 0;
      for (int i = 0; i < 1400 && !found; i++) begin
         @(negedge clk28);
         found = fs_m;
      end
      chk("frame_found", 64'(found), 64'd1);
      if (!found) return;
      e_obs = cyc; ur_obs = ur_m; rdy_obs = rdy_m;
      j = 0;
      for (int k = 0; k < fb; k++) begin
         while (j < k * div + div / 2) begin
            @(negedge clk28);
            j++;
            extra += int'(fs_m | ur_m);
         end
         dv[k]   = data_m;
         smp_exp = (k < 16) ? 2'b01 : (k < 32) ? 2'b10 : 2'b00;
         if (smp_m !== smp_exp) bad_smp++;
         if (smp_m === 2'b01) nl++;
         if (smp_m === 2'b10) nr++;
         if (dclk_m !== 1'b1) bad_dclk++;
      end
      for (int k = 0; k < 16; k++) begin
         l_got[k] = dv[k];
         r_got[k] = dv[16 + k];
      end
      model(sel, m, w_exp, ur_exp, rdy_exp);
      chk("frame_edge",   64'(e_obs), 64'(div + m * div * fb));
      chk("underrun",     64'(ur_obs), 64'(ur_exp));
      chk("s_ready_load", 64'(rdy_obs), 64'(rdy_exp));
      chk("sample_word",  64'({l_got, r_got}), 64'(w_exp));
      chk("smp_pattern",  64'(bad_smp), 64'd0);
      chk("left_slots",   64'(nl), 64'd16);
      chk("right_slots",  64'(nr), 64'd16);
      chk("idle_data",    64'(dv >> 32), 64'd0);
      chk("dclk_mid",     64'(bad_dclk), 64'd0);
      chk("stray_pulse",  64'(extra), 64'd0);
   endtask

   task automatic chk_reset_a();
      chk("rst_dclk",  64'(dclk_a), 64'd0);
      chk("rst_smp",   64'(smp_a), 64'd0);
      chk("rst_data",  64'(data_a), 64'd0);
      chk("rst_ready", 64'(bus_a.s_ready), 64'd1);
      chk("rst_fs",    64'(fs_a), 64'd0);
      chk("rst_ur",    64'(ur_a), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] dv1, dv2, dv3;
      logic [31:0] w_exp;
      logic        ur_exp, rdy_exp;
      logic [4:0]  pat;
      int          e14, mb, e1;
      n_assert = 0; n_fail = 0; sel = 1'b0;
      bus_a.s_valid = 1'b0; bus_a.s_left = '0; bus_a.s_right = '0;
      bus_b.s_valid = 1'b0; bus_b.s_left = '0; bus_b.s_right = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk28);
      chk_reset_a();
      chk("rst_b_smp",   64'(smp_b), 64'd0);
      chk("rst_b_ready", 64'(bus_b.s_ready), 64'd1);
      rst = 1'b0;

      // Underrun zero frame, then a single marker sample.
      capture(0, dv1);
      fork
         send(32'h0001_8000);
         capture(1, dv1);
      join
      chk("marker_bits", 64'(dv1), 64'h0000_8000_0001);

      // Back-to-back random samples: every frame fresh, no underrun.
      fork
         begin for (int i = 0; i < 7; i++) send($urandom); end
         begin for (int f = 2; f < 8; f++) capture(f, dv2); end
      join

      // Supply stops: last sample repeats with an underrun per frame.
      fork
         send(32'h1234_ABCD);
         begin for (int f = 8; f < 12; f++) capture(f, dv2); end
      join

      // Handshake exactly on the slot-0 load edge with hold empty.
      fork
         send_at(16 + 12 * 576, $urandom);
         begin capture(12, dv3); capture(13, dv3); end
      join

      // Reset in the middle of slot 20.
      e14 = 16 + 14 * 576;
      for (int i = 0; i < 2000 && cyc < e14 + 20 * 16 + 8; i++) @(negedge clk28);
      model(1'b0, 14, w_exp, ur_exp, rdy_exp);
      chk("slot20_smp",  64'(smp_a), 64'd2);
      chk("slot20_data", 64'(data_a), 64'(w_exp[4]));
      rst = 1'b1;
      #3;
      chk_reset_a();
      log_a.delete();
      log_b.delete();
      @(negedge clk28);
      rst = 1'b0;
      capture(0, dv1);

      // Minimum configuration: 32-slot frame, 4-cycle bit clock.
      sel = 1'b1;
      send($urandom);
      mb = (cyc - 4) / 128 + 1;
      capture(mb, dv1);
      e1 = 4 + (mb + 1) * 128;
      for (int i = 0; i < 200 && cyc < e1 - 1; i++) @(negedge clk28);
      chk("b_last_slot_smp", 64'(smp_b), 64'd2);
      @(negedge clk28);
      chk("b_next_slot0_smp", 64'(smp_b), 64'd1);
      chk("b_frame_start",    64'(fs_b), 64'd1);
      pat[0] = dclk_b;
      for (int i = 1; i < 5; i++) begin
         @(negedge clk28);
         pat[i] = dclk_b;
      end
      chk("b_dclk_period", 64'(pat), 64'h0C);
      capture(mb + 2, dv1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
